// File: rtl/huc6280_pkg.sv
// Shared HuC6280 peripheral definitions: timer states, register offsets, IRQ bit positions.
package huc6280_pkg;

    typedef enum logic {
        STOPPED = 1'b0,
        RUNNING = 1'b1
    } timer_state_t;

    localparam logic [1:0] TMR_RELOAD = 2'd0;
    localparam logic [1:0] TMR_CTRL   = 2'd1;
    localparam logic [1:0] INT_MASK   = 2'd2;
    localparam logic [1:0] INT_STAT   = 2'd3;

    localparam int IRQ2_BIT = 0;
    localparam int IRQ1_BIT = 1;
    localparam int TIQ_BIT  = 2;

    localparam int unsigned DEF_PRESCALE = 1024;

endpackage

// File: rtl/timer_core.sv
// HuC6280 interval timer: prescaler, down-counter, STOPPED/RUNNING FSM and underflow pulse.
module timer_core
    import huc6280_pkg::*;
#(
    parameter int unsigned PRESCALE = DEF_PRESCALE,
    parameter int unsigned CNT_W    = 7
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             i_reload_we,
    input  logic [CNT_W-1:0] i_reload,
    input  logic             i_ctrl_we,
    input  logic             i_ctrl_run,
    output logic [CNT_W-1:0] o_counter,
    output logic             o_underflow
);

    localparam int unsigned PS_W = (PRESCALE > 2) ? $clog2(PRESCALE) : 1;
    localparam logic [PS_W-1:0] PS_MAX = PS_W'(PRESCALE - 1);

    timer_state_t     r_state, w_state_d;
    logic [CNT_W-1:0] r_counter, w_counter_d;
    logic [CNT_W-1:0] r_reload, w_reload_d;
    logic [PS_W-1:0]  r_ps, w_ps_d;
    logic             w_underflow;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state   <= STOPPED;
            r_counter <= '0;
            r_reload  <= '0;
            r_ps      <= PS_MAX;
        end else begin
            r_state   <= w_state_d;
            r_counter <= w_counter_d;
            r_reload  <= w_reload_d;
            r_ps      <= w_ps_d;
        end
    end

    // A stop write freezes the count on its edge; a run write while RUNNING is a no-op.
    always_comb begin
        w_state_d   = r_state;
        w_counter_d = r_counter;
        w_ps_d      = r_ps;
        w_underflow = 1'b0;
        w_reload_d  = i_reload_we ? i_reload : r_reload;
        if (i_ctrl_we && !i_ctrl_run) begin
            w_state_d = STOPPED;
        end else if (i_ctrl_we && (r_state == STOPPED)) begin
            w_state_d   = RUNNING;
            w_counter_d = r_reload;
            w_ps_d      = PS_MAX;
        end else if (r_state == RUNNING) begin
            if (r_ps != '0) begin
                w_ps_d = r_ps - 1'b1;
            end else begin
                w_ps_d = PS_MAX;
                if (r_counter == '0) begin
                    w_counter_d = r_reload;
                    w_underflow = 1'b1;
                end else begin
                    w_counter_d = r_counter - 1'b1;
                end
            end
        end
    end

    assign o_counter   = r_counter;
    assign o_underflow = w_underflow;

endmodule

// File: rtl/timer_intc.sv
// HuC6280 timer + interrupt controller: chip-enable decode, mask/status registers, read mux,
// masked IRQ outputs.
module timer_intc
    import huc6280_pkg::*;
#(
    parameter int unsigned PRESCALE = DEF_PRESCALE,
    parameter int unsigned CNT_W    = 7
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       RDY,
    input  logic       CET_n,
    input  logic       CECG_n,
    input  logic [1:0] addr,
    input  logic       wr_en,
    input  logic       rd_en,
    input  logic [7:0] d_in,
    output logic [7:0] d_out,
    input  logic       irq1_n,
    input  logic       irq2_n,
    output logic       tiq_req,
    output logic       irq1_req,
    output logic       irq2_req
);

    logic             w_acc, w_tmr_sel, w_int_sel;
    logic             w_tmr_wr, w_int_wr;
    logic             w_reload_we, w_ctrl_we, w_mask_we, w_ack;
    logic [CNT_W-1:0] w_counter;
    logic             w_underflow;
    logic [7:0]       w_rd_data;
    logic             w_unused;

    logic [7:0] r_dout;
    logic [2:0] r_mask;
    logic       r_tiq_pend;
    logic       r_irq1_s, r_irq2_s;

    // The timer enable takes priority should both enables ever be low together.
    assign w_tmr_sel = !CET_n;
    assign w_int_sel = CET_n && !CECG_n;
    assign w_acc     = RDY && (w_tmr_sel || w_int_sel);
    assign w_tmr_wr  = w_acc && wr_en && w_tmr_sel;
    assign w_int_wr  = w_acc && wr_en && w_int_sel;

    assign w_reload_we = w_tmr_wr && (addr[0] == TMR_RELOAD[0]);
    assign w_ctrl_we   = w_tmr_wr && (addr[0] == TMR_CTRL[0]);
    assign w_mask_we   = w_int_wr && (addr == INT_MASK);
    assign w_ack       = w_int_wr && (addr == INT_STAT);
    assign w_unused    = d_in[7];

    timer_core #(
        .PRESCALE (PRESCALE),
        .CNT_W    (CNT_W)
    ) u_timer_core (
        .clk         (clk),
        .reset_n     (reset_n),
        .i_reload_we (w_reload_we),
        .i_reload    (d_in[CNT_W-1:0]),
        .i_ctrl_we   (w_ctrl_we),
        .i_ctrl_run  (d_in[0]),
        .o_counter   (w_counter),
        .o_underflow (w_underflow)
    );

    always_comb begin
        w_rd_data = 8'h00;
        if (w_tmr_sel) begin
            w_rd_data = {{(8 - CNT_W){1'b0}}, w_counter};
        end else if (addr == INT_MASK) begin
            w_rd_data = {5'b0, r_mask};
        end else if (addr == INT_STAT) begin
            w_rd_data = {5'b0, r_tiq_pend, r_irq1_s, r_irq2_s};
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_dout     <= 8'h00;
            r_mask     <= 3'b000;
            r_tiq_pend <= 1'b0;
            r_irq1_s   <= 1'b0;
            r_irq2_s   <= 1'b0;
        end else begin
            r_irq1_s <= !irq1_n;
            r_irq2_s <= !irq2_n;
            if (w_acc && rd_en) begin
                r_dout <= w_rd_data;
            end
            if (w_mask_we) begin
                r_mask <= d_in[2:0];
            end
            // Underflow set beats a same-edge acknowledge.
            if (w_underflow) begin
                r_tiq_pend <= 1'b1;
            end else if (w_ack) begin
                r_tiq_pend <= 1'b0;
            end
        end
    end

    assign d_out    = r_dout;
    assign tiq_req  = r_tiq_pend & !r_mask[TIQ_BIT];
    assign irq1_req = r_irq1_s & !r_mask[IRQ1_BIT];
    assign irq2_req = r_irq2_s & !r_mask[IRQ2_BIT];

endmodule
